// File: rtl/sprite_plotter_pkg.sv
// sprite_plotter_pkg: screen geometry, colour constants and FSM encoding shared by the sprite plotter.
package sprite_plotter_pkg;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int COLOUR_W = 3;
   localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
   localparam logic [COLOUR_W-1:0] WHITE = 3'b111;
   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
endpackage

// File: rtl/sprite_mask_rom.sv
// sprite_mask_rom: per-pixel shape mask for the sprite plotter; only built with SPRITE_PLOTTER_MASK_EN.
// Row 0 is blank and columns 24..31 are cut away, giving a non-rectangular outline.
`ifdef SPRITE_PLOTTER_MASK_EN
module sprite_mask_rom
   import sprite_plotter_pkg::*;
(
   input  logic [4:0] row,
   input  logic [4:0] col,
   output logic       bit_o
);
   assign bit_o = (row != 5'd0) && (col < 5'd24);
endmodule
`endif

// File: rtl/sprite_plotter.sv
// sprite_plotter: turns a latched top-left position and colour into a row-major WIDTHxHEIGHT pixel write stream.
// Define SPRITE_PLOTTER_MASK_EN to gate each pixel with the sprite_mask_rom shape mask.
module sprite_plotter
   import sprite_plotter_pkg::*;
#(
   parameter int WIDTH  = 12,
   parameter int HEIGHT = 12
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [7:0]          x_in,
   input  logic [6:0]          y_in,
   input  logic [COLOUR_W-1:0] colour_in,
   output logic [7:0]          vga_x,
   output logic [6:0]          vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);
   localparam logic [4:0] COL_LAST = 5'(WIDTH - 1);
   localparam logic [4:0] ROW_LAST = 5'(HEIGHT - 1);
   state_t state_q, state_d;
   logic [4:0] col_q, col_d, row_q, row_d;
   logic [7:0] bx_q, bx_d;
   logic [6:0] by_q, by_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic [8:0] sum_x;
   logic [7:0] sum_y;
   logic last_col, last_row, mask_bit;
   assign last_col = col_q == COL_LAST;
   assign last_row = row_q == ROW_LAST;
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      bx_d     = bx_q;
      by_d     = by_q;
      colour_d = colour_q;
      case (state_q)
         IDLE: if (start) begin
            bx_d     = x_in;
            by_d     = y_in;
            colour_d = colour_in;
            col_d    = 5'd0;
            row_d    = 5'd0;
            state_d  = DRAW;
         end
         DRAW: begin
            col_d   = last_col ? 5'd0 : col_q + 5'd1;
            row_d   = last_col ? (last_row ? 5'd0 : row_q + 5'd1) : row_q;
            state_d = (last_col && last_row) ? DONE : DRAW;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         col_q    <= 5'd0;
         row_q    <= 5'd0;
         bx_q     <= 8'd0;
         by_q     <= 7'd0;
         colour_q <= BLACK;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         bx_q     <= bx_d;
         by_q     <= by_d;
         colour_q <= colour_d;
      end
   end
`ifdef SPRITE_PLOTTER_MASK_EN
   sprite_mask_rom u_mask (.row(row_q), .col(col_q), .bit_o(mask_bit));
`else
   assign mask_bit = 1'b1;
`endif
   // Sums are widened so off-screen pixels clip instead of wrapping onto the screen.
   assign sum_x      = {1'b0, bx_q} + {4'd0, col_q};
   assign sum_y      = {1'b0, by_q} + {3'd0, row_q};
   assign vga_x      = sum_x[7:0];
   assign vga_y      = sum_y[6:0];
   assign vga_colour = colour_q;
   assign plot       = (state_q == DRAW) && (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H)) && mask_bit;
   assign busy       = state_q != IDLE;
   assign done       = state_q == DONE;
endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: randomized and directed checks of sprite_plotter against a cycle-offset reference model.
// Expected mask behaviour follows SPRITE_PLOTTER_MASK_EN when it is defined.
module tb_sprite_plotter;
   localparam int W = 12;
   localparam int H = 12;
   localparam int N = W * H;
`ifdef SPRITE_PLOTTER_MASK_EN
   localparam int FULL_PLOTS = N - W;
   localparam int CLIP_PLOTS = 24;
   localparam int MIN_Y_ERASE = 100;
`else
   localparam int FULL_PLOTS = N;
   localparam int CLIP_PLOTS = 30;
   localparam int MIN_Y_ERASE = 99;
`endif
   logic clock = 1'b0, reset = 1'b1, start = 1'b0;
   logic [7:0] x_in = '0;
   logic [6:0] y_in = '0;
   logic [2:0] colour_in = '0;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic plot, busy, done;
   int n_vec = 0, n_bad = 0;
   sprite_plotter #(.WIDTH(W), .HEIGHT(H)) dut (
      .clock(clock), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
      .colour_in(colour_in), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .plot(plot), .busy(busy), .done(done)
   );
   always #5 clock = ~clock;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic bit mask_of(input int r, input int c);
`ifdef SPRITE_PLOTTER_MASK_EN
      return r > 0 && c < 24;
`else
      return (r >= 0) && (c >= 0);
`endif
   endfunction
   // Model: mk = cycles since acceptance (-1 idle); pixel k-1 drawn in cycle k, done in cycle N+1.
   int mk = -1, mbx = 0, mby = 0, mcol = 0;
   bit fresh = 1'b1;
   always @(posedge clock) begin
      if (reset) begin
         mk = -1; mbx = 0; mby = 0; mcol = 0; fresh = 1'b1;
      end else if (mk < 0) begin
         if (start) begin
            mk = 1; mbx = int'(x_in); mby = int'(y_in); mcol = int'(colour_in); fresh = 1'b0;
         end
      end else if (mk == N + 1) mk = -1;
      else mk++;
   end
   always @(negedge clock) begin : cmp
      int idx, sx, sy;
      if (mk >= 1 && mk <= N) begin
         idx = mk - 1;
         sx = mbx + idx % W;
         sy = mby + idx / W;
         chk("draw_x", vga_x, sx & 255);
         chk("draw_y", vga_y, sy & 127);
         chk("draw_colour", vga_colour, mcol);
         chk("draw_plot", plot, (sx < 160 && sy < 120 && mask_of(idx / W, idx % W)) ? 1 : 0);
         chk("draw_busy", busy, 1);
         chk("draw_done", done, 0);
      end else if (mk == N + 1) begin
         chk("done_plot", plot, 0);
         chk("done_busy", busy, 1);
         chk("done_done", done, 1);
      end else begin
         chk("idle_plot", plot, 0);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         if (fresh) begin
            chk("reset_x", vga_x, 0);
            chk("reset_y", vga_y, 0);
            chk("reset_colour", vga_colour, 0);
         end
      end
   end
   int plots, done_at, f_x, f_y, l_x, l_y, min_x, max_x, min_y, max_y, nz_col;
   task automatic draw(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      @(posedge clock); #1;
      start = 1'b1; x_in = x; y_in = y; colour_in = c;
      @(posedge clock); #1;
      start = 1'b0;
      plots = 0; done_at = -1; nz_col = 0;
      min_x = 999; max_x = -1; min_y = 999; max_y = -1;
      for (int k = 1; k <= N + 40; k++) begin
         @(negedge clock);
         if (k == 1) begin f_x = int'(vga_x); f_y = int'(vga_y); end
         if (k == N) begin l_x = int'(vga_x); l_y = int'(vga_y); end
         if (plot) begin
            plots++;
            if (vga_colour != 3'd0) nz_col++;
            if (int'(vga_x) < min_x) min_x = int'(vga_x);
            if (int'(vga_x) > max_x) max_x = int'(vga_x);
            if (int'(vga_y) < min_y) min_y = int'(vga_y);
            if (int'(vga_y) > max_y) max_y = int'(vga_y);
         end
         x_in = 8'($urandom); y_in = 7'($urandom); colour_in = 3'($urandom);
         if (done) begin done_at = k; break; end
      end
      chk("done_timing", done_at, N + 1);
      @(negedge clock);
      chk("busy_after_done", busy, 0);
   endtask
   initial begin
      int cyc, nd, seen_done;
      int d[3];
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("reset_busy_lit", busy, 0);
      draw(8'd14, 7'd99, 3'b111);
      chk("first_x", f_x, 14);
      chk("first_y", f_y, 99);
      chk("last_x", l_x, 25);
      chk("last_y", l_y, 110);
      chk("plots_full", plots, FULL_PLOTS);
      draw(8'd54, 7'd99, 3'b000);
      chk("erase_plots", plots, FULL_PLOTS);
      chk("erase_colour", nz_col, 0);
      chk("erase_min_x", min_x, 54);
      chk("erase_max_x", max_x, 65);
      chk("erase_min_y", min_y, MIN_Y_ERASE);
      chk("erase_max_y", max_y, 110);
      draw(8'd154, 7'd115, 3'b101);
      chk("clip_plots", plots, CLIP_PLOTS);
      chk("clip_max_x", max_x, 159);
      chk("clip_max_y", max_y, 119);
      @(posedge clock); #1;
      start = 1'b1;
      cyc = 0; nd = 0;
      while (nd < 3 && cyc < 600) begin
         @(negedge clock);
         cyc++;
         if (done) begin d[nd] = cyc; nd++; end
         x_in = 8'($urandom); y_in = 7'($urandom); colour_in = 3'($urandom);
      end
      start = 1'b0;
      chk("held_dones", nd, 3);
      if (nd == 3) begin
         chk("held_period1", d[1] - d[0], N + 2);
         chk("held_period2", d[2] - d[1], N + 2);
      end
      repeat (2) @(negedge clock);
      @(posedge clock); #1;
      start = 1'b1; x_in = 8'd30; y_in = 7'd40; colour_in = 3'd3;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (50) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_plot", plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_x", vga_x, 0);
      chk("rst_y", vga_y, 0);
      chk("rst_colour", vga_colour, 0);
      seen_done = 0;
      repeat (N + 10) begin
         @(negedge clock);
         if (done) seen_done++;
      end
      chk("no_done_after_reset", seen_done, 0);
      draw(8'd20, 7'd10, 3'b010);
      chk("plots_after_reset", plots, FULL_PLOTS);
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 4)) @(posedge clock);
         draw(8'($urandom), 7'($urandom), 3'($urandom));
      end
      repeat (3) @(posedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
